pc_redirect_unit: RTL and testbench
===================================

Name: pc_redirect_unit

Overview:
- Owns the fetch PC register and turns the ID-stage control decode into PC redirects.
- Consumes Jump[1:0] and Branch from the control decoder, plus the branch compare result and operands. Produces next PC, IF/ID flush and a misalignment trap.
- Sits between the control decoder, the forwarding path and the instruction-fetch stage.

Parameters:
- ADDR_W, 32, PC/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_PC, 32'h0000_0080, PC loaded when a redirect target is misaligned.
- FLUSH_CYCLES, 1, IF/ID squash cycles after a redirect (1..3).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard stall; freezes PC, pc_id and flush counter.
- jump  in  2  from control: 00 none, 01 JR via rs_data, 10 JR via fwd_data (forwarded), 11 J-type absolute.
- branch  in  1  from control: conditional branch in ID.
- branch_taken  in  1  ID compare result; meaningful only with branch=1.
- imm16  in  16  branch offset field of the ID instruction.
- instr_index  in  26  J-type target field.
- rs_data  in  ADDR_W  register-file rs value.
- fwd_data  in  ADDR_W  forwarded result of the previous instruction.
- pc  out  ADDR_W  current fetch address.
- pc_plus4  out  ADDR_W  pc+4, combinational.
- flush_if  out  1  squash the instruction entering IF/ID.
- redirect  out  1  one-cycle pulse when a redirect is committed.
- misalign_err  out  1  sticky misaligned-target flag.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, pc_id=RESET_PC, state=RUN, flush count=0, flush_if=0, redirect=0, misalign_err=0. Release takes effect on the next rising edge.
- pc_id register: holds the PC of the instruction in ID. It loads pc on every non-stalled edge.
- Target computation, combinational, mod 2^ADDR_W:
  - br_tgt = pc_id+4 + (sign_extend(imm16)<<2).
  - j_tgt = {pc_id_plus4[31:28], instr_index, 2'b00}.
  - jr_tgt = rs_data when jump=01, fwd_data when jump=10.
- Request priority in state RUN: jump!=00 first, then branch&&branch_taken, otherwise sequential pc+4.
- Branch with branch_taken=0 behaves as no request.
- A redirect commits only on an edge with stall=0. While stall=1, pc, pc_id and state hold, redirect=0, and the request is re-evaluated each cycle.
- Commit edge:
  - Target[1:0]==00: pc<=target.
  - Target[1:0]!=00: pc<=TRAP_PC and misalign_err<=1. misalign_err stays set until reset.
  - redirect=1 for exactly this cycle following the edge. State goes to FLUSH with count=FLUSH_CYCLES.
- State FLUSH:
  - flush_if=1.
  - jump/branch inputs are ignored, because the ID instruction is a squashed bubble.
  - pc advances by +4 on non-stalled edges.
  - Count decrements only on non-stalled edges. At count 1→0 the state returns to RUN.
  - stall holds the count and keeps flush_if asserted.
- State RUN: flush_if=0.
- Back-to-back control transfers (jump in the delay slot) are squashed by FLUSH and never redirect.
- Wrap-around: pc+4 from 32'hFFFF_FFFC gives 32'h0000_0000, with no flag.
- Latency: request visible in ID → pc updated at the next non-stalled edge, 1 cycle.

Test Plan:
- Reset: rst_n low mid-FLUSH, asynchronously → pc=0, flush_if=0, redirect=0, misalign_err=0 immediately; after release pc steps 0,4,8.
- JR forwarding: pc_id=0x40, jump=10, fwd_data=0x200, rs_data=0x300 → pc=0x200 next edge, redirect pulses 1 cycle, flush_if=1 for 1 cycle, then pc=0x204. Same with jump=01 → pc=0x300.
- Branch: pc_id=0x100, branch=1, branch_taken=1, imm16=0xFFFC → pc=0xF4. With branch_taken=0 → pc=pc+4, no flush.
- Stall during request: jump=11, instr_index=0x0000040, stall=1 for 3 cycles → pc and pc_id frozen, redirect=0; stall drops → pc=0x100 on that edge.
- Misaligned JR: jump=01, rs_data=0x202 → pc=TRAP_PC (0x80), misalign_err=1, sticky through 10 further cycles.
- Delay-slot transfer with FLUSH_CYCLES=2: a second jump presented during FLUSH → ignored, and flush_if stays high for exactly 2 non-stalled cycles.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - fetch PC register with jump/branch redirect, IF/ID flush and misalignment trap
module pc_redirect_unit #(
    parameter int                 ADDR_W       = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC     = '0,
    parameter logic [ADDR_W-1:0]  TRAP_PC      = ADDR_W'('h80),
    parameter int                 FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [1:0]        jump,
    input  logic              branch,
    input  logic              branch_taken,
    input  logic [15:0]       imm16,
    input  logic [25:0]       instr_index,
    input  logic [ADDR_W-1:0] rs_data,
    input  logic [ADDR_W-1:0] fwd_data,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              flush_if,
    output logic              redirect,
    output logic              misalign_err
);

    // Jump encodings from the control decoder.
    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_RS   = 2'b01;
    localparam logic [1:0] JUMP_FWD  = 2'b10;
    localparam logic [1:0] JUMP_ABS  = 2'b11;

    // Squash length loaded on every committed redirect (legal range 1..3).
    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES);

    localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        cnt_q;
    logic [1:0]        cnt_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_id_q;
    logic              redirect_q;
    logic              redirect_d;
    logic              err_q;
    logic              err_d;

    logic [ADDR_W-1:0] pc_id_plus4;
    logic [ADDR_W-1:0] imm_ext;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] j_tgt;
    logic [ADDR_W-1:0] jr_tgt;

    logic              req_valid;
    logic [ADDR_W-1:0] req_tgt;
    logic              tgt_misaligned;

    // Candidate targets, all relative to the instruction currently in ID.
    always_comb begin
        pc_id_plus4 = pc_id_q + FOUR;
        imm_ext     = {{(ADDR_W-16){imm16[15]}}, imm16};
        br_tgt      = pc_id_plus4 + (imm_ext << 2);
        j_tgt       = {pc_id_plus4[ADDR_W-1:28], instr_index, 2'b00};
        jr_tgt      = (jump == JUMP_FWD) ? fwd_data : rs_data;
    end

    // Request arbitration: any jump beats a taken branch; an untaken branch is no request.
    always_comb begin
        req_valid = 1'b0;
        req_tgt   = '0;
        unique case (jump)
            JUMP_RS, JUMP_FWD: begin
                req_valid = 1'b1;
                req_tgt   = jr_tgt;
            end
            JUMP_ABS: begin
                req_valid = 1'b1;
                req_tgt   = j_tgt;
            end
            JUMP_NONE: begin
                if (branch && branch_taken) begin
                    req_valid = 1'b1;
                    req_tgt   = br_tgt;
                end
            end
            default: begin
                req_valid = 1'b0;
                req_tgt   = '0;
            end
        endcase
        tgt_misaligned = (req_tgt[1:0] != 2'b00);
    end

    // Next-state logic: stall freezes everything; FLUSH drains the squash counter while
    // fetching sequentially; RUN commits a redirect or steps to pc+4.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        redirect_d = 1'b0;
        err_d      = err_q;

        if (!stall) begin
            unique case (state_q)
                ST_RUN: begin
                    if (req_valid) begin
                        redirect_d = 1'b1;
                        state_d    = ST_FLUSH;
                        cnt_d      = FLUSH_INIT;
                        if (tgt_misaligned) begin
                            pc_d  = TRAP_PC;
                            err_d = 1'b1;
                        end else begin
                            pc_d  = req_tgt;
                        end
                    end else begin
                        pc_d = pc_q + FOUR;
                    end
                end
                ST_FLUSH: begin
                    // The ID slot holds a squashed bubble, so its control bits are ignored.
                    pc_d  = pc_q + FOUR;
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = 2'd0;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    // Fetch PC, FSM state and squash counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            state_q <= ST_RUN;
            cnt_q   <= 2'd0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // PC of the instruction in ID follows the fetch PC one stage behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_id_q <= RESET_PC;
        end else if (!stall) begin
            pc_id_q <= pc_q;
        end
    end

    // One-cycle redirect pulse and sticky misalignment flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            redirect_q <= redirect_d;
            err_q      <= err_d;
        end
    end

    // Output drive.
    always_comb begin
        pc           = pc_q;
        pc_plus4     = pc_q + FOUR;
        flush_if     = (state_q == ST_FLUSH);
        redirect     = redirect_q;
        misalign_err = err_q;
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb/tb_pc_redirect_unit.sv - randomized and directed bench for pc_redirect_unit (FLUSH_CYCLES 1 and 2)
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  jump = 2'b00;
    logic        branch = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] imm16 = '0;
    logic [25:0] instr_index = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] fwd_data = '0;

    logic [31:0] o_pc [2];
    logic [31:0] o_p4 [2];
    logic        o_fl [2];
    logic        o_red [2];
    logic        o_err [2];

    int vectors = 0;
    int miscompares = 0;

    // Reference state: instance 0 squashes 1 cycle, instance 1 squashes 2.
    logic [31:0] m_pc [2];
    logic [31:0] m_pc_id [2];
    int          m_cnt [2];
    logic        m_red [2];
    logic        m_err [2];

    always #5 clk = ~clk;

    pc_redirect_unit #(.FLUSH_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .stall(stall), .jump(jump), .branch(branch),
        .branch_taken(branch_taken), .imm16(imm16), .instr_index(instr_index),
        .rs_data(rs_data), .fwd_data(fwd_data), .pc(o_pc[0]), .pc_plus4(o_p4[0]),
        .flush_if(o_fl[0]), .redirect(o_red[0]), .misalign_err(o_err[0])
    );

    pc_redirect_unit #(.FLUSH_CYCLES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .stall(stall), .jump(jump), .branch(branch),
        .branch_taken(branch_taken), .imm16(imm16), .instr_index(instr_index),
        .rs_data(rs_data), .fwd_data(fwd_data), .pc(o_pc[1]), .pc_plus4(o_p4[1]),
        .flush_if(o_fl[1]), .redirect(o_red[1]), .misalign_err(o_err[1])
    );

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 32'h0; m_pc_id[k] = 32'h0; m_cnt[k] = 0; m_red[k] = 1'b0; m_err[k] = 1'b0;
        end
    endtask

    task automatic quiet_inputs();
        stall = 1'b0; jump = 2'b00; branch = 1'b0; branch_taken = 1'b0;
        imm16 = '0; instr_index = '0; rs_data = '0; fwd_data = '0;
    endtask

    // Apply one clock edge to DUT and reference; returns at posedge+1.
    task automatic step();
        logic [31:0] npc [2];
        logic [31:0] nid [2];
        int          ncnt [2];
        logic        nred [2];
        logic        nerr [2];
        logic [31:0] tgt;
        logic [31:0] seq4;
        logic        req;
        for (int k = 0; k < 2; k++) begin
            npc[k] = m_pc[k]; nid[k] = m_pc_id[k]; ncnt[k] = m_cnt[k];
            nred[k] = 1'b0; nerr[k] = m_err[k];
            if (!stall) begin
                nid[k] = m_pc[k];
                if (m_cnt[k] > 0) begin
                    npc[k]  = m_pc[k] + 32'd4;
                    ncnt[k] = m_cnt[k] - 1;
                end else begin
                    req  = 1'b1;
                    tgt  = 32'h0;
                    seq4 = m_pc_id[k] + 32'd4;
                    case (jump)
                        2'b01: tgt = rs_data;
                        2'b10: tgt = fwd_data;
                        2'b11: tgt = {seq4[31:28], instr_index, 2'b00};
                        default: begin
                            if (branch && branch_taken)
                                tgt = seq4 + 32'($signed(imm16)) * 32'd4;
                            else
                                req = 1'b0;
                        end
                    endcase
                    if (req) begin
                        nred[k] = 1'b1;
                        ncnt[k] = k + 1;
                        if (tgt % 4 != 0) begin
                            npc[k] = 32'h80;
                            nerr[k] = 1'b1;
                        end else begin
                            npc[k] = tgt;
                        end
                    end else begin
                        npc[k] = m_pc[k] + 32'd4;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = npc[k]; m_pc_id[k] = nid[k]; m_cnt[k] = ncnt[k];
            m_red[k] = nred[k]; m_err[k] = nerr[k];
        end
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst_n = 1'b0;
        #3;
        model_reset();
        rst_n = 1'b1;
    endtask

    // Step with quiet inputs until the reference pc_id reaches the wanted value.
    task automatic advance_to_pc_id(input logic [31:0] want);
        int n = 0;
        quiet_inputs();
        while (m_pc_id[0] !== want && n < 1000) begin
            step();
            n++;
        end
        vectors++;
        if (m_pc_id[0] !== want) begin
            miscompares++;
            $display("FAIL advance_timeout got pc_id %h want %h", m_pc_id[0], want);
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            vectors += 4;
            if (o_pc[k] !== 32'h0) begin miscompares++; $display("FAIL reset_pc k=%0d got %h want 0", k, o_pc[k]); end
            if (o_fl[k] !== 1'b0) begin miscompares++; $display("FAIL reset_flush k=%0d got %b want 0", k, o_fl[k]); end
            if (o_red[k] !== 1'b0) begin miscompares++; $display("FAIL reset_redirect k=%0d got %b want 0", k, o_red[k]); end
            if (o_err[k] !== 1'b0) begin miscompares++; $display("FAIL reset_err k=%0d got %b want 0", k, o_err[k]); end
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            vectors++;
            if (o_pc[0] !== 32'(4 * i)) begin miscompares++; $display("FAIL reset_seq got %h want %h", o_pc[0], 32'(4 * i)); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        jump = 2'b10; fwd_data = 32'h500;
        step();
        jump = 2'b00;
        vectors++;
        if (o_fl[0] !== 1'b1) begin miscompares++; $display("FAIL async_pre_flush got %b want 1", o_fl[0]); end
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            vectors += 4;
            if (o_pc[k] !== 32'h0) begin miscompares++; $display("FAIL async_pc k=%0d got %h want 0", k, o_pc[k]); end
            if (o_fl[k] !== 1'b0) begin miscompares++; $display("FAIL async_flush k=%0d got %b want 0", k, o_fl[k]); end
            if (o_red[k] !== 1'b0) begin miscompares++; $display("FAIL async_redirect k=%0d got %b want 0", k, o_red[k]); end
            if (o_err[k] !== 1'b0) begin miscompares++; $display("FAIL async_err k=%0d got %b want 0", k, o_err[k]); end
        end
        model_reset();
        rst_n = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            step();
            vectors++;
            if (o_pc[1] !== 32'(4 * i)) begin miscompares++; $display("FAIL async_seq got %h want %h", o_pc[1], 32'(4 * i)); end
        end
    endtask

    task automatic test_jr_forward();
        do_reset();
        advance_to_pc_id(32'h40);
        jump = 2'b10; fwd_data = 32'h200; rs_data = 32'h300;
        step();
        jump = 2'b00;
        vectors += 3;
        if (o_pc[0] !== 32'h200) begin miscompares++; $display("FAIL jrf_pc got %h want 200", o_pc[0]); end
        if (o_red[0] !== 1'b1) begin miscompares++; $display("FAIL jrf_redirect got %b want 1", o_red[0]); end
        if (o_fl[0] !== 1'b1) begin miscompares++; $display("FAIL jrf_flush got %b want 1", o_fl[0]); end
        step();
        vectors += 4;
        if (o_pc[0] !== 32'h204) begin miscompares++; $display("FAIL jrf_seq got %h want 204", o_pc[0]); end
        if (o_red[0] !== 1'b0) begin miscompares++; $display("FAIL jrf_pulse got %b want 0", o_red[0]); end
        if (o_fl[0] !== 1'b0) begin miscompares++; $display("FAIL jrf_flush_end got %b want 0", o_fl[0]); end
        if (o_fl[1] !== 1'b1) begin miscompares++; $display("FAIL jrf_flush2 got %b want 1", o_fl[1]); end
        jump = 2'b01;
        step();
        jump = 2'b00;
        vectors++;
        if (o_pc[0] !== 32'h300) begin miscompares++; $display("FAIL jrs_pc got %h want 300", o_pc[0]); end
    endtask

    task automatic test_branch();
        do_reset();
        advance_to_pc_id(32'h100);
        branch = 1'b1; branch_taken = 1'b1; imm16 = 16'hFFFC;
        step();
        branch = 1'b0; branch_taken = 1'b0;
        vectors += 2;
        if (o_pc[0] !== 32'hF4) begin miscompares++; $display("FAIL br_pc got %h want f4", o_pc[0]); end
        if (o_fl[0] !== 1'b1) begin miscompares++; $display("FAIL br_flush got %b want 1", o_fl[0]); end
        step();
        vectors++;
        if (o_pc[0] !== 32'hF8) begin miscompares++; $display("FAIL br_seq got %h want f8", o_pc[0]); end
        branch = 1'b1; branch_taken = 1'b0;
        step();
        branch = 1'b0;
        vectors += 3;
        if (o_pc[0] !== 32'hFC) begin miscompares++; $display("FAIL br_nt_pc got %h want fc", o_pc[0]); end
        if (o_fl[0] !== 1'b0) begin miscompares++; $display("FAIL br_nt_flush got %b want 0", o_fl[0]); end
        if (o_red[0] !== 1'b0) begin miscompares++; $display("FAIL br_nt_redirect got %b want 0", o_red[0]); end
    endtask

    task automatic test_stall();
        do_reset();
        advance_to_pc_id(32'h20);
        jump = 2'b11; instr_index = 26'h40; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors += 2;
            if (o_pc[0] !== 32'h24) begin miscompares++; $display("FAIL stall_pc got %h want 24", o_pc[0]); end
            if (o_red[0] !== 1'b0) begin miscompares++; $display("FAIL stall_redirect got %b want 0", o_red[0]); end
        end
        stall = 1'b0;
        step();
        jump = 2'b00;
        vectors += 2;
        if (o_pc[0] !== 32'h100) begin miscompares++; $display("FAIL stall_release_pc got %h want 100", o_pc[0]); end
        if (o_red[0] !== 1'b1) begin miscompares++; $display("FAIL stall_release_redirect got %b want 1", o_red[0]); end
    endtask

    task automatic test_misalign();
        do_reset();
        jump = 2'b01; rs_data = 32'h202;
        step();
        jump = 2'b00;
        vectors += 2;
        if (o_pc[0] !== 32'h80) begin miscompares++; $display("FAIL mis_pc got %h want 80", o_pc[0]); end
        if (o_err[0] !== 1'b1) begin miscompares++; $display("FAIL mis_err got %b want 1", o_err[0]); end
        for (int i = 0; i < 10; i++) begin
            step();
            vectors++;
            if (o_err[0] !== 1'b1) begin miscompares++; $display("FAIL mis_sticky cyc=%0d got %b want 1", i, o_err[0]); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        jump = 2'b01; rs_data = 32'hFFFF_FFF8;
        step();
        jump = 2'b00;
        step();
        vectors += 2;
        if (o_pc[0] !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_pc got %h want fffffffc", o_pc[0]); end
        if (o_p4[0] !== 32'h0) begin miscompares++; $display("FAIL wrap_plus4 got %h want 0", o_p4[0]); end
        step();
        vectors += 2;
        if (o_pc[0] !== 32'h0) begin miscompares++; $display("FAIL wrap_next got %h want 0", o_pc[0]); end
        if (o_err[0] !== 1'b0) begin miscompares++; $display("FAIL wrap_err got %b want 0", o_err[0]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc [4];
        logic        exp_fl [4];
        logic        stl [4];
        exp_pc = '{32'h200, 32'h200, 32'h204, 32'h208};
        exp_fl = '{1'b1, 1'b1, 1'b1, 1'b0};
        stl    = '{1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        advance_to_pc_id(32'h10);
        jump = 2'b11; instr_index = 26'h80;
        for (int i = 0; i < 4; i++) begin
            stall = stl[i];
            step();
            if (i == 0) instr_index = 26'h100;
            vectors += 2;
            if (o_pc[1] !== exp_pc[i]) begin miscompares++; $display("FAIL b2b_pc cyc=%0d got %h want %h", i, o_pc[1], exp_pc[i]); end
            if (o_fl[1] !== exp_fl[i]) begin miscompares++; $display("FAIL b2b_flush cyc=%0d got %b want %b", i, o_fl[1], exp_fl[i]); end
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (o_pc[k] !== m_pc[k]) begin miscompares++; $display("FAIL b2b_model_pc k=%0d got %h want %h", k, o_pc[k], m_pc[k]); end
            end
        end
        quiet_inputs();
    endtask

    task automatic test_random();
        logic [31:0] r;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r = $urandom;
            stall        = (r[1:0] == 2'b00);
            jump         = (r[4:2] == 3'b000) ? r[6:5] : 2'b00;
            branch       = r[7];
            branch_taken = r[8];
            imm16        = 16'($urandom);
            instr_index  = 26'($urandom);
            rs_data      = {$urandom_range(0, 32'h3FFF_FFFF), (r[12:9] == 4'h0) ? r[14:13] : 2'b00};
            fwd_data     = {$urandom_range(0, 32'h3FFF_FFFF), (r[18:15] == 4'h0) ? r[20:19] : 2'b00};
            if (r[31:26] == 6'h0) begin
                do_reset();
            end else begin
                step();
            end
            for (int k = 0; k < 2; k++) begin
                vectors += 5;
                if (o_pc[k] !== m_pc[k]) begin miscompares++; $display("FAIL rnd_pc i=%0d k=%0d got %h want %h", i, k, o_pc[k], m_pc[k]); end
                if (o_p4[k] !== m_pc[k] + 32'd4) begin miscompares++; $display("FAIL rnd_plus4 i=%0d k=%0d got %h want %h", i, k, o_p4[k], m_pc[k] + 32'd4); end
                if (o_fl[k] !== (m_cnt[k] > 0)) begin miscompares++; $display("FAIL rnd_flush i=%0d k=%0d got %b want %b", i, k, o_fl[k], m_cnt[k] > 0); end
                if (o_red[k] !== m_red[k]) begin miscompares++; $display("FAIL rnd_redirect i=%0d k=%0d got %b want %b", i, k, o_red[k], m_red[k]); end
                if (o_err[k] !== m_err[k]) begin miscompares++; $display("FAIL rnd_err i=%0d k=%0d got %b want %b", i, k, o_err[k], m_err[k]); end
            end
        end
        quiet_inputs();
    endtask

    initial begin
        test_reset();
        test_jr_forward();
        test_branch();
        test_stall();
        test_misalign();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
